// File: rtl/fetch_prefetch_queue.sv
// Prefetching fetch unit: sequential IMEM requests buffered into a
// DEPTH-entry queue of {instr, pc} with redirect/flush and backpressure.
module fetch_prefetch_queue #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           INSTR_WIDTH = 32,
    parameter int unsigned           DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned           PC_STEP     = 4
) (
    input  logic                         Clk,
    input  logic                         Reset,
    output logic                         ImemReqValid,
    output logic [ADDR_WIDTH-1:0]        ImemReqAddr,
    input  logic                         ImemRespValid,
    input  logic [INSTR_WIDTH-1:0]       ImemRespData,
    input  logic                         Redirect,
    input  logic [ADDR_WIDTH-1:0]        RedirectPC,
    input  logic                         Stall,
    output logic                         OutValid,
    input  logic                         OutReady,
    output logic [INSTR_WIDTH-1:0]       OutInstruction,
    output logic [ADDR_WIDTH-1:0]        OutPC,
    output logic [ADDR_WIDTH-1:0]        OutPCNext,
    output logic [$clog2(DEPTH+1)-1:0]   Count
);

    localparam int unsigned           PW   = $clog2(DEPTH);
    localparam int unsigned           CW   = $clog2(DEPTH+1);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);
    localparam logic [CW:0]           CAP  = (CW+1)'(DEPTH);

    logic [INSTR_WIDTH-1:0] q_instr [DEPTH];
    logic [ADDR_WIDTH-1:0]  q_pc    [DEPTH];

    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [CW-1:0]         count;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] inflight_pc;
    logic                  inflight;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [CW:0]           credit;

    assign pop  = (count != '0) && OutReady;
    assign push = ImemRespValid && inflight && !Redirect;

    // Slots already promised (queued + in flight) minus the one leaving now.
    assign credit = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign issue  = !Reset && !Redirect && !Stall && (credit < CAP);

    assign ImemReqValid = issue;
    assign ImemReqAddr  = fetch_pc;
    assign Count        = count;
    assign OutValid     = (count != '0);

    always_comb begin
        OutInstruction = '0;
        OutPC          = '0;
        OutPCNext      = '0;
        if (OutValid) begin
            OutInstruction = q_instr[rptr];
            OutPC          = q_pc[rptr];
            OutPCNext      = q_pc[rptr] + STEP;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
        end else if (Redirect) begin
            fetch_pc <= RedirectPC;
            inflight <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
        end else begin
            if (issue) begin
                fetch_pc    <= fetch_pc + STEP;
                inflight_pc <= fetch_pc;
                inflight    <= 1'b1;
            end else if (ImemRespValid) begin
                inflight <= 1'b0;
            end
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset && push) begin
            q_instr[wptr] <= ImemRespData;
            q_pc[wptr]    <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed testbench for fetch_prefetch_queue with a one-cycle IMEM model
// whose word at byte address k is 0x1000_0000 + k.
module tb_fetch_prefetch_queue;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ImemReqValid;
    logic [31:0] ImemReqAddr;
    logic        ImemRespValid = 1'b0;
    logic [31:0] ImemRespData = '0;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        Stall;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] OutInstruction;
    logic [31:0] OutPC;
    logic [31:0] OutPCNext;
    logic [2:0]  Count;
    logic        spur;

    int total  = 0;
    int passed = 0;

    fetch_prefetch_queue dut (
        .Clk(Clk), .Reset(Reset),
        .ImemReqValid(ImemReqValid), .ImemReqAddr(ImemReqAddr),
        .ImemRespValid(ImemRespValid), .ImemRespData(ImemRespData),
        .Redirect(Redirect), .RedirectPC(RedirectPC), .Stall(Stall),
        .OutValid(OutValid), .OutReady(OutReady),
        .OutInstruction(OutInstruction), .OutPC(OutPC),
        .OutPCNext(OutPCNext), .Count(Count)
    );

    always #5 Clk = ~Clk;

    // spur injects a response with no request outstanding
    always @(posedge Clk) begin
        ImemRespValid <= ImemReqValid | spur;
        ImemRespData  <= 32'h1000_0000 + ImemReqAddr;
    end

    always @(negedge Clk) begin
        if (Reset === 1'b0)
            assert (Count <= 3'd4) else $error("FAIL invariant count=%0d", Count);
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic next();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; Redirect = 1'b0; RedirectPC = '0;
        Stall = 1'b0; OutReady = 1'b0; spur = 1'b0;
        next();
        next();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Redirect = 1'b0; RedirectPC = '0;
        Stall = 1'b0; OutReady = 1'b1; spur = 1'b0;
        next();
        next();
        #1;
        total++;
        if (ImemReqValid !== 1'b0) $display("FAIL rst_reqvalid got %0b exp 0", ImemReqValid);
        else passed++;
        total++;
        if (OutValid !== 1'b0 || Count !== 3'd0)
            $display("FAIL rst_state got valid=%0b count=%0d exp 0/0", OutValid, Count);
        else passed++;
        total++;
        if (ImemReqAddr !== 32'h0 || OutInstruction !== 32'h0 || OutPC !== 32'h0)
            $display("FAIL rst_data got addr=%h instr=%h pc=%h exp 0", ImemReqAddr, OutInstruction, OutPC);
        else passed++;
        Reset = 1'b0;
        #1;
        total++;
        if (ImemReqValid !== 1'b1 || ImemReqAddr !== 32'h0)
            $display("FAIL rst_first_req got v=%0b a=%h exp 1/0", ImemReqValid, ImemReqAddr);
        else passed++;
    endtask

    task automatic test_stream();
        logic [31:0] e;
        do_reset();
        OutReady = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            total++;
            if (c < 2) begin
                if (OutValid !== 1'b0) $display("FAIL stream_lat c%0d got valid=%0b exp 0", c, OutValid);
                else passed++;
            end else begin
                e = 32'(4 * (c - 2));
                if (OutValid !== 1'b1 || OutPC !== e || OutInstruction !== 32'h1000_0000 + e
                    || OutPCNext !== e + 32'd4)
                    $display("FAIL stream c%0d got v=%0b pc=%h ins=%h nx=%h exp pc=%h", c,
                             OutValid, OutPC, OutInstruction, OutPCNext, e);
                else passed++;
            end
            next();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] addrs [8];
        int nreq;
        do_reset();
        nreq = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (ImemReqValid === 1'b1 && nreq < 8) begin
                addrs[nreq] = ImemReqAddr;
                nreq++;
            end
            next();
        end
        total++;
        if (nreq !== 4) $display("FAIL bp_nreq got %0d exp 4", nreq);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (addrs[k] !== 32'(4 * k)) $display("FAIL bp_addr%0d got %h exp %h", k, addrs[k], 4 * k);
            else passed++;
        end
        #1;
        total++;
        if (Count !== 3'd4 || ImemReqValid !== 1'b0)
            $display("FAIL bp_full got count=%0d req=%0b exp 4/0", Count, ImemReqValid);
        else passed++;
        OutReady = 1'b1;
        #1;
        total++;
        if (ImemReqValid !== 1'b1 || ImemReqAddr !== 32'h10)
            $display("FAIL bp_resume got v=%0b a=%h exp 1/10", ImemReqValid, ImemReqAddr);
        else passed++;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (OutValid !== 1'b1 || OutPC !== 32'(4 * k))
                $display("FAIL bp_drain%0d got v=%0b pc=%h exp 1/%h", k, OutValid, OutPC, 4 * k);
            else passed++;
            next();
            #1;
        end
    endtask

    task automatic test_redirect_flush();
        do_reset();
        repeat (4) next();
        #1;
        total++;
        if (Count !== 3'd3) $display("FAIL rf_pre_count got %0d exp 3", Count);
        else passed++;
        Redirect = 1'b1;
        RedirectPC = 32'h200;
        #1;
        total++;
        if (ImemReqValid !== 1'b0) $display("FAIL rf_noreq got %0b exp 0", ImemReqValid);
        else passed++;
        next();
        Redirect = 1'b0;
        OutReady = 1'b1;
        #1;
        total++;
        if (Count !== 3'd0 || OutValid !== 1'b0)
            $display("FAIL rf_flush got count=%0d v=%0b exp 0/0", Count, OutValid);
        else passed++;
        total++;
        if (ImemReqValid !== 1'b1 || ImemReqAddr !== 32'h200)
            $display("FAIL rf_req got v=%0b a=%h exp 1/200", ImemReqValid, ImemReqAddr);
        else passed++;
        next();
        #1;
        total++;
        if (OutValid !== 1'b0) $display("FAIL rf_gap got v=%0b exp 0", OutValid);
        else passed++;
        next();
        #1;
        total++;
        if (OutValid !== 1'b1 || OutPC !== 32'h200 || OutInstruction !== 32'h1000_0200)
            $display("FAIL rf_first got v=%0b pc=%h ins=%h exp 1/200/10000200", OutValid, OutPC, OutInstruction);
        else passed++;
        next();
        #1;
        total++;
        if (OutValid !== 1'b1 || OutPC !== 32'h204)
            $display("FAIL rf_second got v=%0b pc=%h exp 1/204", OutValid, OutPC);
        else passed++;
    endtask

    task automatic test_redirect_pop();
        do_reset();
        OutReady = 1'b1;
        repeat (4) next();
        #1;
        total++;
        if (OutValid !== 1'b1 || OutPC !== 32'h8)
            $display("FAIL rp_head got v=%0b pc=%h exp 1/8", OutValid, OutPC);
        else passed++;
        Redirect = 1'b1;
        RedirectPC = 32'h40;
        next();
        Redirect = 1'b0;
        #1;
        total++;
        if (OutValid !== 1'b0 || Count !== 3'd0 || ImemReqAddr !== 32'h40 || ImemReqValid !== 1'b1)
            $display("FAIL rp_flush got v=%0b cnt=%0d a=%h exp 0/0/40", OutValid, Count, ImemReqAddr);
        else passed++;
        next();
        #1;
        total++;
        if (OutValid !== 1'b0) $display("FAIL rp_gap got v=%0b pc=%h exp 0", OutValid, OutPC);
        else passed++;
        next();
        #1;
        total++;
        if (OutValid !== 1'b1 || OutPC !== 32'h40)
            $display("FAIL rp_new got v=%0b pc=%h exp 1/40", OutValid, OutPC);
        else passed++;
    endtask

    task automatic test_stall();
        do_reset();
        OutReady = 1'b1;
        repeat (4) next();
        Stall = 1'b1;
        for (int c = 4; c < 7; c++) begin
            #1;
            total++;
            if (ImemReqValid !== 1'b0) $display("FAIL st_noreq c%0d got %0b exp 0", c, ImemReqValid);
            else passed++;
            total++;
            if (c == 6) begin
                if (OutValid !== 1'b0) $display("FAIL st_out c%0d got v=%0b exp 0", c, OutValid);
                else passed++;
            end else if (OutValid !== 1'b1 || OutPC !== 32'(c == 4 ? 8 : 12))
                $display("FAIL st_out c%0d got v=%0b pc=%h exp %0d", c, OutValid, OutPC, c == 4 ? 8 : 12);
            else passed++;
            spur = (c == 5);
            next();
        end
        spur = 1'b0;
        Stall = 1'b0;
        #1;
        total++;
        if (ImemReqValid !== 1'b1 || ImemReqAddr !== 32'h10)
            $display("FAIL st_resume got v=%0b a=%h exp 1/10", ImemReqValid, ImemReqAddr);
        else passed++;
        total++;
        if (Count !== 3'd0 || OutValid !== 1'b0)
            $display("FAIL st_spurious got cnt=%0d v=%0b exp 0/0", Count, OutValid);
        else passed++;
        next();
        next();
        #1;
        total++;
        if (OutValid !== 1'b1 || OutPC !== 32'h10)
            $display("FAIL st_after got v=%0b pc=%h exp 1/10", OutValid, OutPC);
        else passed++;
        next();
        #1;
        total++;
        if (OutValid !== 1'b1 || OutPC !== 32'h14)
            $display("FAIL st_after2 got v=%0b pc=%h exp 1/14", OutValid, OutPC);
        else passed++;
    endtask

    task automatic test_wrap();
        Redirect = 1'b1;
        RedirectPC = 32'hFFFF_FFFC;
        OutReady = 1'b1;
        next();
        Redirect = 1'b0;
        #1;
        total++;
        if (ImemReqValid !== 1'b1 || ImemReqAddr !== 32'hFFFF_FFFC)
            $display("FAIL wr_req0 got v=%0b a=%h exp 1/fffffffc", ImemReqValid, ImemReqAddr);
        else passed++;
        next();
        #1;
        total++;
        if (ImemReqValid !== 1'b1 || ImemReqAddr !== 32'h0)
            $display("FAIL wr_req1 got v=%0b a=%h exp 1/0", ImemReqValid, ImemReqAddr);
        else passed++;
        next();
        #1;
        total++;
        if (OutPC !== 32'hFFFF_FFFC || OutPCNext !== 32'h0 || OutInstruction !== 32'h0FFF_FFFC)
            $display("FAIL wr_out0 got pc=%h nx=%h ins=%h exp fffffffc/0/0ffffffc", OutPC, OutPCNext, OutInstruction);
        else passed++;
        next();
        #1;
        total++;
        if (OutValid !== 1'b1 || OutPC !== 32'h0 || OutInstruction !== 32'h1000_0000)
            $display("FAIL wr_out1 got v=%0b pc=%h ins=%h exp 1/0/10000000", OutValid, OutPC, OutInstruction);
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (3) next();
        #1;
        total++;
        if (Count !== 3'd2) $display("FAIL rm_pre got %0d exp 2", Count);
        else passed++;
        Reset = 1'b1;
        next();
        Reset = 1'b0;
        #1;
        total++;
        if (OutValid !== 1'b0 || Count !== 3'd0 || ImemReqAddr !== 32'h0 || ImemReqValid !== 1'b1)
            $display("FAIL rm_post got v=%0b cnt=%0d a=%h r=%0b exp 0/0/0/1", OutValid, Count, ImemReqAddr, ImemReqValid);
        else passed++;
        next();
        #1;
        total++;
        if (Count !== 3'd0) $display("FAIL rm_late got %0d exp 0", Count);
        else passed++;
        next();
        #1;
        total++;
        if (Count !== 3'd1 || OutValid !== 1'b1 || OutPC !== 32'h0)
            $display("FAIL rm_first got cnt=%0d v=%0b pc=%h exp 1/1/0", Count, OutValid, OutPC);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_redirect_pop();
        test_stall();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
Parametrised successor to the single-cycle fetch unit. It decouples PC sequencing from the decode stage by issuing sequential requests to a fixed-latency synchronous instruction memory. Returned instructions are buffered, together with their PC and PC+step, in a DEPTH-entry FIFO. It sits between the program-counter/IMEM pair and decode. It supports redirect with flush (jumps and branches), fetch stall, and decode backpressure via a valid/ready handshake.

Parameters:
ADDR_WIDTH, 32, width of PC and memory address
INSTR_WIDTH, 32, width of instruction word
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 0, fetch address loaded on reset
PC_STEP, 4, sequential PC increment

Ports:
Clk  in  1  clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
ImemReqValid  out  1  fetch request this cycle
ImemReqAddr  out  ADDR_WIDTH  request address (current FetchPC)
ImemRespValid  in  1  response valid; asserted exactly 1 cycle after the request
ImemRespData  in  INSTR_WIDTH  returned instruction
Redirect  in  1  load RedirectPC, flush queue and in-flight request
RedirectPC  in  ADDR_WIDTH  new fetch address
Stall  in  1  suppress new requests; queue still drains
OutValid  out  1  head entry valid
OutReady  in  1  decode accepts head
OutInstruction  out  INSTR_WIDTH  head instruction
OutPC  out  ADDR_WIDTH  PC of head instruction
OutPCNext  out  ADDR_WIDTH  OutPC + PC_STEP, modulo 2^ADDR_WIDTH
Count  out  clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (synchronous, wins over all inputs):
  - FetchPC <= RESET_PC.
  - Queue empty, read/write pointers 0, in-flight flag 0.
  - OutValid=0, Count=0.
  - Data outputs are don't-care while OutValid=0; drive 0.
- Issue rule (combinational):
  - ImemReqValid = !Reset_state_cycle && !Redirect && !Stall && (Count + InFlight - Pop < DEPTH).
  - Pop = OutValid && OutReady.
  - ImemReqAddr = FetchPC.
  - On issue: FetchPC <= FetchPC + PC_STEP, wrapping modulo 2^ADDR_WIDTH. InFlight <= 1, and the request PC is recorded in InFlightPC.
  - No issue in the cycle Reset is high.
- Response: when ImemRespValid && InFlight && !Redirect, write {ImemRespData, InFlightPC} at the write pointer; write pointer increments modulo DEPTH. ImemRespValid while InFlight=0 is ignored.
- Latency: request in cycle n -> response in cycle n+1 -> written at the end of n+1 -> OutValid in n+2. There is no bypass path.
  - After reset deasserts, the first request is in cycle 0 and OutValid=1 in cycle 2.
- Throughput: with OutReady held high and Stall low, the block delivers 1 instruction/cycle sustained for any DEPTH >= 2.
- Output: head entry registered in the FIFO. OutValid = (Count != 0). The read pointer increments on Pop.
- Simultaneous push and pop: Count unchanged. Full with pop and response in the same cycle is legal; the credit rule guarantees no overflow.
- Empty: OutValid=0, and OutReady is ignored.
- Redirect (priority over issue, response and Stall; below Reset):
  - A Pop in the redirect cycle counts as a completed handshake.
  - Then the queue is flushed (pointers and Count to 0).
  - InFlight <= 0, so a response arriving next cycle is discarded.
  - FetchPC <= RedirectPC.
  - No request in the redirect cycle. The next cycle requests RedirectPC if not stalled, and OutValid rises 2 cycles after that request.
  - RedirectPC is used unmodified; no alignment check.
- Stall: blocks issue only. A response already in flight is still written, and pops continue.
- Invariant: Count + InFlight <= DEPTH at all times. Overflow and underflow are impossible by construction; the bench asserts this.

Test Plan:
- Reset then OutReady=1, DEPTH=4, IMEM word at addr k = 0x1000_0000+k -> from cycle 2, OutPC = 0, 4, 8, ... on consecutive cycles; OutInstruction matches; OutPCNext = OutPC+4.
- OutReady=0 for 10 cycles after reset -> exactly 4 requests (addrs 0, 4, 8, 12), then ImemReqValid=0; Count=4. Raising OutReady drains 0, 4, 8, 12 with no gap, and fetch resumes at 16.
- Redirect to 0x200 while Count=3 and a request is in flight -> next cycle Count=0, OutValid=0, stale response dropped. The following cycle issues 0x200, and the first OutPC is 0x200 with no stale instruction delivered.
- Redirect and Pop in the same cycle with head PC=0x8 -> 0x8 counted as consumed; queue flushed; no duplicate 0x8.
- Stall=1 for 3 cycles mid-stream -> no requests during the stall, in-flight response still enqueued, PC sequence contiguous after release. Separately, FetchPC=0xFFFF_FFFC wraps the next request to 0x0.
- Reset asserted with Count=2 and a request in flight -> next cycle OutValid=0, Count=0, ImemReqAddr=RESET_PC, and the late response is ignored.
